// File: rtl/block_word_bridge.sv
// Block-to-word bridge: serializes 256-bit block reads/writes into word beats on a narrow SRAM port.
// Optional BLOCK_WORD_BRIDGE_WRITE_VERIFY_EN adds a read-back verify pass after every block write.
module block_word_bridge #(
    parameter int ADDR_W = 16,
    parameter int WORD_W = 32,
    parameter int BEATS  = 8,
    parameter int RD_LAT = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [ADDR_W-1:0]         mem_addr_block,
    input  logic [WORD_W*BEATS-1:0]   mem_wdata_block,
    input  logic                      mem_read,
    input  logic                      mem_write,
    output logic [WORD_W*BEATS-1:0]   mem_rdata_block,
    output logic                      mem_ready,
    output logic [ADDR_W-1:0]         word_addr,
    output logic [WORD_W-1:0]         word_wdata,
    output logic                      word_we,
    output logic                      word_re,
    input  logic [WORD_W-1:0]         word_rdata,
    output logic                      verify_err
);
    localparam int BW = $clog2(BEATS);
    localparam int LO = BW + 2;
    localparam logic [BW-1:0] LAST = BW'(BEATS - 1);

    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] WR_BEATS = 3'd1;
    localparam logic [2:0] RD_ISSUE = 3'd2;
    localparam logic [2:0] RD_DRAIN = 3'd3;
    localparam logic [2:0] RESP     = 3'd4;
    localparam logic [2:0] HOLDOFF  = 3'd5;

    logic [2:0]                      state;
    logic [BW-1:0]                   beat;
    logic [BW-1:0]                   cap;
    logic [ADDR_W-1:LO]              addr_q;
    logic [BEATS-1:0][WORD_W-1:0]    wdata_q;
    logic [BEATS-2:0][WORD_W-1:0]    rbuf;
    logic [RD_LAT-1:0]               vld_pipe;
    logic                            capture;
    logic                            unused_addr_lo;

    assign unused_addr_lo = ^mem_addr_block[LO-1:0];

    // Strobes decode straight from state so a reset kills them on the very next cycle.
    assign word_we    = (state == WR_BEATS);
    assign word_re    = (state == RD_ISSUE);
    assign mem_ready  = (state == RESP);
    assign word_addr  = (word_we || word_re) ? {addr_q, beat, 2'b00} : '0;
    assign word_wdata = word_we ? wdata_q[beat] : '0;
    assign capture    = vld_pipe[RD_LAT-1];

`ifdef BLOCK_WORD_BRIDGE_WRITE_VERIFY_EN
    logic verify_q;
    logic verify_err_q;
    assign verify_err = verify_err_q;
`else
    assign verify_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            beat            <= '0;
            cap             <= '0;
            addr_q          <= '0;
            wdata_q         <= '0;
            rbuf            <= '0;
            vld_pipe        <= '0;
            mem_rdata_block <= '0;
`ifdef BLOCK_WORD_BRIDGE_WRITE_VERIFY_EN
            verify_q        <= 1'b0;
            verify_err_q    <= 1'b0;
`endif
        end else begin
            // vld_pipe[k] marks a read issued k+1 cycles ago; the last tap is a valid word_rdata.
            vld_pipe[0] <= word_re;
            for (int i = 1; i < RD_LAT; i++) vld_pipe[i] <= vld_pipe[i-1];

            if (capture) begin
                cap <= cap + 1'b1;
`ifdef BLOCK_WORD_BRIDGE_WRITE_VERIFY_EN
                if (verify_q) begin
                    if (word_rdata != wdata_q[cap]) verify_err_q <= 1'b1;
                end else
`endif
                if (cap == LAST) mem_rdata_block <= {word_rdata, rbuf};
                else             rbuf[cap]       <= word_rdata;
            end

            case (state)
                IDLE: begin
                    beat <= '0;
                    cap  <= '0;
                    if (mem_write) begin
                        addr_q  <= mem_addr_block[ADDR_W-1:LO];
                        wdata_q <= mem_wdata_block;
                        state   <= WR_BEATS;
                    end else if (mem_read) begin
                        addr_q  <= mem_addr_block[ADDR_W-1:LO];
                        state   <= RD_ISSUE;
`ifdef BLOCK_WORD_BRIDGE_WRITE_VERIFY_EN
                        verify_q <= 1'b0;
`endif
                    end
                end
                WR_BEATS: begin
                    beat <= beat + 1'b1;
                    if (beat == LAST) begin
                        beat <= '0;
`ifdef BLOCK_WORD_BRIDGE_WRITE_VERIFY_EN
                        verify_q <= 1'b1;
                        state    <= RD_ISSUE;
`else
                        state    <= RESP;
`endif
                    end
                end
                RD_ISSUE: begin
                    beat <= beat + 1'b1;
                    if (beat == LAST) begin
                        beat  <= '0;
                        state <= RD_DRAIN;
                    end
                end
                RD_DRAIN: if (capture && cap == LAST) state <= RESP;
                RESP:     state <= HOLDOFF;
                HOLDOFF:  state <= IDLE;
                default:  state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_block_word_bridge.sv
// Directed bench for block_word_bridge with a 1-cycle-latency word memory model.
module tb_block_word_bridge;
    logic         clk = 1'b0;
    logic         rst;
    logic [15:0]  mem_addr_block;
    logic [255:0] mem_wdata_block;
    logic         mem_read, mem_write;
    logic [255:0] mem_rdata_block;
    logic         mem_ready;
    logic [15:0]  word_addr;
    logic [31:0]  word_wdata;
    logic         word_we, word_re;
    logic [31:0]  word_rdata;
    logic         verify_err;

    int n_cmp = 0;
    int n_bad = 0;
    int we_cnt = 0, re_cnt = 0, both_hi = 0;
    logic [15:0] we_addr_log[$];
    logic [31:0] we_data_log[$];
    logic [31:0] wmem [0:16383];
    bit corrupt = 1'b0;

    block_word_bridge dut (
        .clk(clk), .rst(rst),
        .mem_addr_block(mem_addr_block), .mem_wdata_block(mem_wdata_block),
        .mem_read(mem_read), .mem_write(mem_write),
        .mem_rdata_block(mem_rdata_block), .mem_ready(mem_ready),
        .word_addr(word_addr), .word_wdata(word_wdata),
        .word_we(word_we), .word_re(word_re), .word_rdata(word_rdata),
        .verify_err(verify_err)
    );

    always #5 clk = ~clk;

    // Word memory: corrupt mode flips bit 0 of whatever lands at 0x020C.
    always @(posedge clk) begin
        if (word_we)
            wmem[word_addr[15:2]] <= (corrupt && word_addr == 16'h020C) ? (word_wdata ^ 32'h1) : word_wdata;
        if (word_re)
            word_rdata <= wmem[word_addr[15:2]];
    end

    always @(negedge clk) begin
        if (word_we) begin
            we_cnt++;
            we_addr_log.push_back(word_addr);
            we_data_log.push_back(word_wdata);
        end
        if (word_re) re_cnt++;
        if (word_we && word_re) both_hi++;
    end

    function automatic logic [255:0] blk(input logic [31:0] base);
        logic [255:0] b;
        for (int i = 0; i < 8; i++) b[32*i +: 32] = base + 32'(i);
        return b;
    endfunction

    task automatic clear_logs();
        we_cnt = 0; re_cnt = 0;
        we_addr_log.delete(); we_data_log.delete();
    endtask

    // Issue one request; lat is the cycle index of mem_ready (cycle 1 follows the acceptance edge), -1 on timeout.
    task automatic do_req(input bit w, input bit r, input logic [15:0] a, input logic [255:0] d, output int lat);
        repeat (2) @(negedge clk);
        mem_write = w; mem_read = r; mem_addr_block = a; mem_wdata_block = d;
        lat = -1;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            if (k == 2) begin mem_addr_block = 16'hFFFF; mem_wdata_block = ~d; end
            if (mem_ready) begin lat = k; break; end
        end
        mem_write = 1'b0; mem_read = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; mem_read = 1'b0; mem_write = 1'b0;
        mem_addr_block = '0; mem_wdata_block = '0;
        repeat (2) @(negedge clk);
        n_cmp++; if ({mem_ready, word_we, word_re, verify_err} !== 4'b0) begin n_bad++;
            $display("FAIL reset_strobes: got %b want 0000", {mem_ready, word_we, word_re, verify_err}); end
        n_cmp++; if (word_addr !== 16'h0 || word_wdata !== 32'h0) begin n_bad++;
            $display("FAIL reset_word_bus: addr %h data %h want 0", word_addr, word_wdata); end
        n_cmp++; if (mem_rdata_block !== 256'h0) begin n_bad++;
            $display("FAIL reset_rdata: got %h want 0", mem_rdata_block); end
        rst = 1'b0;
    endtask

    task automatic test_write();
        int lat;
        clear_logs();
        do_req(1'b1, 1'b0, 16'h1240, blk(32'hA5A50000), lat);
        n_cmp++; if (lat != 9) begin n_bad++; $display("FAIL write_latency: got %0d want 9", lat); end
        n_cmp++; if (we_cnt != 8 || re_cnt != 0) begin n_bad++;
            $display("FAIL write_beats: we %0d re %0d want 8 0", we_cnt, re_cnt); end
        for (int i = 0; i < 8 && i < we_addr_log.size(); i++) begin
            n_cmp++; if (we_addr_log[i] !== 16'h1240 + 16'(4*i) || we_data_log[i] !== 32'hA5A50000 + 32'(i)) begin
                n_bad++; $display("FAIL write_beat%0d: addr %h data %h want %h %h", i, we_addr_log[i],
                    we_data_log[i], 16'h1240 + 16'(4*i), 32'hA5A50000 + 32'(i)); end
        end
    endtask

    task automatic test_read();
        int lat;
        clear_logs();
        do_req(1'b0, 1'b1, 16'h125F, '0, lat);
        n_cmp++; if (lat != 10) begin n_bad++; $display("FAIL read_latency: got %0d want 10", lat); end
        n_cmp++; if (re_cnt != 8 || we_cnt != 0) begin n_bad++;
            $display("FAIL read_beats: re %0d we %0d want 8 0", re_cnt, we_cnt); end
        n_cmp++; if (mem_rdata_block[31:0] !== 32'hA5A50000 || mem_rdata_block[255:224] !== 32'hA5A50007) begin
            n_bad++; $display("FAIL read_edge_words: %h %h want a5a50000 a5a50007",
                mem_rdata_block[31:0], mem_rdata_block[255:224]); end
        repeat (4) @(negedge clk);
        n_cmp++; if (mem_rdata_block !== blk(32'hA5A50000)) begin n_bad++;
            $display("FAIL read_block_hold: got %h want %h", mem_rdata_block, blk(32'hA5A50000)); end
    endtask

    task automatic test_both_high();
        int lat;
        clear_logs();
        do_req(1'b1, 1'b1, 16'h0020, blk(32'h11110000), lat);
        n_cmp++; if (lat != 9) begin n_bad++; $display("FAIL both_latency: got %0d want 9", lat); end
        n_cmp++; if (we_cnt != 8 || re_cnt != 0) begin n_bad++;
            $display("FAIL both_beats: we %0d re %0d want 8 0", we_cnt, re_cnt); end
        n_cmp++; if (we_addr_log.size() > 0 && we_addr_log[0] !== 16'h0020) begin n_bad++;
            $display("FAIL both_addr: got %h want 0020", we_addr_log[0]); end
        n_cmp++; if (mem_rdata_block !== blk(32'hA5A50000)) begin n_bad++;
            $display("FAIL both_rdata_kept: got %h want %h", mem_rdata_block, blk(32'hA5A50000)); end
    endtask

    task automatic test_back_to_back();
        int pulses[$];
        int second_we;
        clear_logs();
        second_we = -1;
        repeat (2) @(negedge clk);
        mem_write = 1'b1; mem_addr_block = 16'h0100; mem_wdata_block = blk(32'h22220000);
        for (int k = 1; k <= 31; k++) begin
            @(negedge clk);
            if (mem_ready) pulses.push_back(k);
            if (word_we && k > 9 && second_we < 0) second_we = k;
        end
        mem_write = 1'b0;
        n_cmp++; if (pulses.size() != 3) begin n_bad++;
            $display("FAIL b2b_pulse_count: got %0d want 3", pulses.size()); end
        n_cmp++; if (pulses.size() >= 2 && (pulses[0] != 9 || pulses[1] - pulses[0] != 11)) begin n_bad++;
            $display("FAIL b2b_spacing: first %0d gap %0d want 9 11", pulses[0], pulses[1] - pulses[0]); end
        n_cmp++; if (second_we != 12) begin n_bad++;
            $display("FAIL b2b_reaccept: first beat at %0d want 12", second_we); end
        n_cmp++; if (both_hi != 0) begin n_bad++; $display("FAIL we_re_overlap: got %0d want 0", both_hi); end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int lat, rdy;
        rdy = 0;
        repeat (2) @(negedge clk);
        mem_read = 1'b1; mem_addr_block = 16'h1240;
        repeat (4) @(negedge clk);
        n_cmp++; if (word_re !== 1'b1 || word_addr !== 16'h124C) begin n_bad++;
            $display("FAIL mid_beat4: re %b addr %h want 1 124c", word_re, word_addr); end
        rst = 1'b1; mem_read = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        n_cmp++; if ({mem_ready, word_we, word_re} !== 3'b0 || word_addr !== 16'h0 || mem_rdata_block !== 256'h0) begin
            n_bad++; $display("FAIL mid_reset_outputs: rdy %b we %b re %b addr %h", mem_ready, word_we, word_re, word_addr); end
        for (int k = 0; k < 15; k++) begin @(negedge clk); if (mem_ready) rdy++; end
        n_cmp++; if (rdy != 0) begin n_bad++; $display("FAIL mid_no_ready: got %0d pulses want 0", rdy); end
        do_req(1'b0, 1'b1, 16'h1240, '0, lat);
        n_cmp++; if (lat != 10 || mem_rdata_block !== blk(32'hA5A50000)) begin n_bad++;
            $display("FAIL mid_recover: lat %0d data %h", lat, mem_rdata_block); end
    endtask

    task automatic test_verify();
        int lat;
        corrupt = 1'b1;
        do_req(1'b1, 1'b0, 16'h0200, blk(32'h33330000), lat);
        corrupt = 1'b0;
`ifdef BLOCK_WORD_BRIDGE_WRITE_VERIFY_EN
        n_cmp++; if (lat != 18) begin n_bad++; $display("FAIL verify_latency: got %0d want 18", lat); end
        @(negedge clk);
        n_cmp++; if (verify_err !== 1'b1) begin n_bad++; $display("FAIL verify_err_set: got %b want 1", verify_err); end
        do_req(1'b1, 1'b0, 16'h0300, blk(32'h44440000), lat);
        n_cmp++; if (verify_err !== 1'b1) begin n_bad++; $display("FAIL verify_err_sticky: got %b want 1", verify_err); end
`else
        n_cmp++; if (lat != 9) begin n_bad++; $display("FAIL verify_latency: got %0d want 9", lat); end
        @(negedge clk);
        n_cmp++; if (verify_err !== 1'b0) begin n_bad++; $display("FAIL verify_err_tied: got %b want 0", verify_err); end
`endif
        n_cmp++; if (mem_rdata_block !== blk(32'hA5A50000)) begin n_bad++;
            $display("FAIL verify_rdata_kept: got %h want %h", mem_rdata_block, blk(32'hA5A50000)); end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_both_high();
        test_back_to_back();
        test_reset_mid();
        test_verify();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/block_word_bridge.md
Name: block_word_bridge

Overview:
- Memory-side responder for the data cache's 256-bit block refill/writeback interface (mem_addr_block / mem_wdata_block / mem_read / mem_write / mem_rdata_block / mem_ready).
- Serializes each block request into 8 word beats on a 32-bit word-wide SRAM port, then returns one assembled block.
- Sits between data_cache and a narrow word memory as a drop-in alternative to a native block-wide memory.

Parameters:
- ADDR_W, 16, byte address width on both sides.
- WORD_W, 32, word bus width.
- BEATS, 8, words per block (BLOCK = WORD_W*BEATS = 256).
- RD_LAT, 1, fixed word-read latency in cycles (word_rdata valid RD_LAT cycles after word_re); legal range 1..4.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- mem_addr_block  in  ADDR_W  block byte address; low 5 bits ignored
- mem_wdata_block  in  256  writeback data
- mem_read  in  1  block read request, level, held until mem_ready
- mem_write  in  1  block write request, level, held until mem_ready
- mem_rdata_block  out  256  refill data
- mem_ready  out  1  one-cycle completion pulse
- word_addr  out  ADDR_W  word byte address
- word_wdata  out  WORD_W  write word
- word_we  out  1  word write strobe
- word_re  out  1  word read strobe
- word_rdata  in  WORD_W  read word, valid RD_LAT cycles after word_re
- verify_err  out  1  sticky write-verify mismatch (see Optional Feature)

Behaviour:
- Reset: all outputs 0; state IDLE; beat counters 0; mem_rdata_block 0.
- Clock and reset: single clock clk; reset rst is synchronous and active-high.
- Beat mapping: beat i (0..7) ↔ block bits [32i+31:32i].
  - word_addr = {mem_addr_block[15:5], i[2:0], 2'b00}.
  - Request address and wdata are latched in IDLE on acceptance.
- States: IDLE, WR_BEATS, RD_ISSUE, RD_DRAIN, RESP, HOLDOFF.
- IDLE:
  - mem_write=1 → WR_BEATS.
  - else mem_read=1 → RD_ISSUE.
  - Both high → write has priority; read ignored; cache must re-present it.
- WR_BEATS:
  - word_we=1 for 8 consecutive cycles, beats 0..7.
  - After beat 7 → RESP.
  - Write latency: acceptance edge to mem_ready = 9 cycles.
- RD_ISSUE:
  - word_re=1 for 8 consecutive cycles, beats 0..7.
  - A capture counter stores word_rdata into slot j exactly RD_LAT cycles after beat j was issued.
  - After beat 7 issues → RD_DRAIN until slot 7 is captured → RESP.
  - Read latency: 9+RD_LAT cycles.
- RESP:
  - mem_ready=1 for exactly one cycle.
  - mem_rdata_block holds the full block from this cycle until the next read's RESP; it is unchanged by writes.
- HOLDOFF:
  - One cycle; request inputs ignored so a still-high level is not re-accepted; → IDLE.
- Inputs changing mid-transaction are ignored; the latched copies are used.
- word_we and word_re are never high in the same cycle. Both are 0 outside beat cycles.
- Reset mid-transaction:
  - Aborts the transaction; no further strobes from the next cycle; no mem_ready.
  - Read captures still in flight are discarded.
- Back-to-back: minimum spacing between mem_ready pulses is 11 cycles for writes (9 + HOLDOFF + IDLE).

Optional Feature:
- Macro: BLOCK_WORD_BRIDGE_WRITE_VERIFY_EN.
- Defined:
  - After WR_BEATS, a VERIFY pass re-reads all 8 beats (same timing as RD_ISSUE/RD_DRAIN) and compares each against the latched wdata. RESP follows the pass.
  - Write latency becomes 17+RD_LAT cycles.
  - Any mismatch sets verify_err; it stays set until rst.
  - mem_rdata_block is not updated by the verify pass.
- Undefined: no VERIFY state; verify_err tied 0.

Test Plan:
- Write at addr 0x1240, wdata word i = 0xA5A50000+i → word_we beats at word_addr 0x1240..0x125C, word_wdata as given; mem_ready pulses 9 cycles after acceptance.
- Read at 0x1240 (RD_LAT=1), model returns the stored words → mem_ready at cycle 10; mem_rdata_block[31:0]=0xA5A50000 and [255:224]=0xA5A50007.
- mem_read and mem_write both high at 0x0020 → write-only sequence, no word_re; mem_rdata_block unchanged.
- Request held high after mem_ready → exactly one transaction per pulse; new acceptance no earlier than 2 cycles after mem_ready.
- rst asserted on the 4th read beat → next cycle all outputs 0, no mem_ready; a subsequent read completes normally.
- With BLOCK_WORD_BRIDGE_WRITE_VERIFY_EN, model corrupts beat 3 on write → verify_err=1 after RESP and stays 1; without the macro, verify_err stays 0.
